// File: rtl/s_memory_pkg.sv
// Shared constants and the shuffle FSM state type for the S-memory blocks
// (init, shuffle, arbiter).
package s_memory_pkg;

  localparam int ADDR_W    = 8;
  localparam int KEY_BYTES = 3;
  localparam int KEY_IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_INDEX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SI  = 3'd1,
    CAP_SI = 3'd2,
    RD_SJ  = 3'd3,
    CAP_SJ = 3'd4,
    WR_SI  = 3'd5,
    WR_SJ  = 3'd6,
    DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/s_memory_shuffle_if.sv
// Control and S-RAM bus of the KSA shuffle block.
//
// Handshake: start is a level that is sampled only while the block is idle;
// busy is high from the first cycle of a pass through the done cycle; done is
// a single-cycle pulse at the end of the pass. The RAM side has no handshake:
// the RAM registers address at a rising edge and presents q during the
// following cycle; write_enable qualifies data at the rising edge.
interface s_memory_shuffle_if;
  import s_memory_pkg::*;

  logic                     start;
  logic [8*KEY_BYTES-1:0]   secret_key;
  logic [ADDR_W-1:0]        q;
  logic [ADDR_W-1:0]        address;
  logic [ADDR_W-1:0]        data;
  logic                     write_enable;
  logic                     busy;
  logic                     done;

  // Shuffle block side
  modport master (
    input  start, secret_key, q,
    output address, data, write_enable, busy, done
  );

  // Controller / RAM side
  modport slave (
    output start, secret_key, q,
    input  address, data, write_enable, busy, done
  );

endinterface

// File: rtl/key_byte_sel.sv
// Picks key byte k out of the latched key; key[0] is the most significant byte.
module key_byte_sel
  import s_memory_pkg::*;
(
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KEY_IDX_W-1:0]   k,
  output logic [ADDR_W-1:0]      key_byte
);

  // Plain mux over the byte lanes; k never exceeds KEY_BYTES-1.
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == KEY_IDX_W'(n)) key_byte = key[8*(KEY_BYTES-1-n) +: 8];
    end
  end

endmodule

// File: rtl/s_memory_shuffle.sv
// RC4 key-scheduling pass over the 256-byte S RAM. Six cycles per index:
// read S[i], capture it and update j, read S[j], capture it, write both back
// swapped.
module s_memory_shuffle
  import s_memory_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  s_memory_shuffle_if.master   bus,
  output state_t               state_dbg
);

  state_t                 state, state_nxt;
  logic [8*KEY_BYTES-1:0] key_r;
  logic [ADDR_W-1:0]      i, j, si, sj;
  logic [KEY_IDX_W-1:0]   k;
  logic [ADDR_W-1:0]      key_byte;
  logic [ADDR_W-1:0]      address_c, data_c;
  logic                   we_c;

  key_byte_sel u_key_byte_sel (
    .key      (key_r),
    .k        (k),
    .key_byte (key_byte)
  );

  // State register; reset aborts a pass immediately, dropping write_enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and RAM bus decode; bus outputs depend only on state and registers.
  always_comb begin
    state_nxt = state;
    address_c = '0;
    data_c    = '0;
    we_c      = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = RD_SI;
      RD_SI: begin
        address_c = i;
        state_nxt = CAP_SI;
      end
      CAP_SI: state_nxt = RD_SJ;
      RD_SJ: begin
        address_c = j;
        state_nxt = CAP_SJ;
      end
      CAP_SJ: state_nxt = WR_SI;
      WR_SI: begin
        address_c = i;
        data_c    = sj;
        we_c      = 1'b1;
        state_nxt = WR_SJ;
      end
      WR_SJ: begin
        address_c = j;
        data_c    = si;
        we_c      = 1'b1;
        state_nxt = (i == LAST_INDEX) ? DONE : RD_SI;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index, key and swap-operand registers; key is latched once per pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_r <= bus.secret_key;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end
        end
        CAP_SI: begin
          si <= bus.q;
          j  <= j + bus.q + key_byte;
        end
        CAP_SJ: sj <= bus.q;
        WR_SJ: begin
          if (i != LAST_INDEX) begin
            i <= i + 1'b1;
            k <= (k == KEY_IDX_W'(KEY_BYTES-1)) ? '0 : k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address      = address_c;
  assign bus.data         = data_c;
  assign bus.write_enable = we_c;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign state_dbg        = state;

endmodule

// File: tb/tb_s_memory_shuffle.sv
// Bench for s_memory_shuffle: behavioural 256x8 RAM with one-cycle read
// latency, reference KSA model feeding an expected-write queue, final-S compare.
module tb_s_memory_shuffle;
  import s_memory_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;

  s_memory_shuffle_if bus ();

  s_memory_shuffle dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [7:0] mem [256];
  logic [7:0] ram_q;
  logic       init_req;

  always @(posedge clk) begin
    if (init_req) begin
      for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
    end else if (bus.write_enable) begin
      mem[bus.address] <= bus.data;
    end
    ram_q <= mem[bus.address];
  end
  assign bus.q = ram_q;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  logic [7:0]  ref_s [256];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every RAM write is compared, in order, against the reference write list.
  always @(negedge clk) begin
    if (!reset && bus.write_enable) begin
      wr_log.push_back({bus.address, bus.data});
      if (exp_q.size() == 0) check("wr_extra", {bus.address, bus.data}, 32'hFFFF_FFFF);
      else check("wr", {bus.address, bus.data}, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_identity();
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
  endtask

  // One KSA pass on ref_s, queueing the two writes of each iteration.
  task automatic gen_pass(input logic [23:0] key);
    logic [7:0] rj, a, b, kb;
    rj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      kb = 8'(key >> (8 * (2 - (n % 3))));
      rj = rj + ref_s[n] + kb;
      a  = ref_s[n];
      b  = ref_s[rj];
      exp_q.push_back({8'(n), b});
      exp_q.push_back({rj, a});
      ref_s[n]  = b;
      ref_s[rj] = a;
    end
  endtask

  task automatic compare_s();
    for (int n = 0; n < 256; n++) check("s_final", mem[n], ref_s[n]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_ram();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Start one pass and watch it for 1540 cycles; optionally churn start/key.
  task automatic run_pass(input logic [23:0] key, input bit toggle);
    int done_cyc, done_cnt, busy_cnt, we_cnt;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; we_cnt = 0;
    wr_log.delete();
    @(negedge clk);
    bus.secret_key = key;
    bus.start      = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 1540; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.write_enable) we_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (toggle && c < 1400) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.secret_key = 24'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    check("done_cycle", done_cyc, 1537);
    check("done_count", done_cnt, 1);
    check("busy_cycles", busy_cnt, 1537);
    check("we_cycles", we_cnt, 512);
    check("wr_left", exp_q.size(), 0);
    compare_s();
  endtask

  int d1, d2;

  initial begin
    reset = 1'b1;
    init_req = 1'b0;
    bus.start = 1'b0;
    bus.secret_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_address", bus.address, 0);
    check("rst_data", bus.data, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    reset = 1'b0;

    // 1: all-zero key, spot-check iterations 2 and 3
    init_ram();
    ref_identity();
    gen_pass(24'h000000);
    run_pass(24'h000000, 1'b0);
    check("k0_wr4", wr_log.size() > 7 ? wr_log[4] : 16'hFFFF, 16'h0203);
    check("k0_wr5", wr_log.size() > 7 ? wr_log[5] : 16'hFFFF, 16'h0302);
    check("k0_wr6", wr_log.size() > 7 ? wr_log[6] : 16'hFFFF, 16'h0305);
    check("k0_wr7", wr_log.size() > 7 ? wr_log[7] : 16'hFFFF, 16'h0502);

    // 2/3: key 010203, first swap and timing
    init_ram();
    ref_identity();
    gen_pass(24'h010203);
    run_pass(24'h010203, 1'b0);
    check("k1_wr0", wr_log.size() > 1 ? wr_log[0] : 16'hFFFF, 16'h0001);
    check("k1_wr1", wr_log.size() > 1 ? wr_log[1] : 16'hFFFF, 16'h0100);

    // 4: start held high across two passes
    init_ram();
    ref_identity();
    gen_pass(24'hA5_3C_7E);
    gen_pass(24'hA5_3C_7E);
    d1 = 0; d2 = 0;
    @(negedge clk);
    bus.secret_key = 24'hA5_3C_7E;
    bus.start      = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3080; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (d1 != 0 && c == d1 + 1) check("hold_gap_idle", bus.busy, 0);
      if (d1 != 0 && c == d1 + 2) begin
        check("hold_restart_busy", bus.busy, 1);
        check("hold_restart_addr", bus.address, 0);
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("hold_done1", d1, 1537);
    check("hold_done2", d2, 3075);
    check("hold_wr_left", exp_q.size(), 0);
    compare_s();

    // 5: reset in a write cycle of the pass, then a clean re-run
    init_ram();
    ref_identity();
    gen_pass(24'h123456);
    @(negedge clk);
    bus.secret_key = 24'h123456;
    bus.start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (699) @(negedge clk);
    // cycle 701 is a WR_SI cycle, so write_enable is high before reset
    @(posedge clk);
    #1;
    check("pre_rst_we", bus.write_enable, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_we", bus.write_enable, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_addr", bus.address, 0);
    check("mid_rst_done", bus.done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    init_ram();
    ref_identity();
    gen_pass(24'h123456);
    run_pass(24'h123456, 1'b0);

    // 6: start and key churn during the pass must not matter
    init_ram();
    ref_identity();
    gen_pass(24'hDE_AD_01);
    run_pass(24'hDE_AD_01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
